ad_sync_ctrl: RTL

//  Sequencer for the dual-channel ADC capture FIFOs (I on adc_clk100m, Q on adc_clk_b).

---
 rtl/ad_sync_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/ad_sync_ctrl.sv
// Power-up and fault-recovery sequencer for the dual-channel ADC capture FIFOs.
// Walks STARTUP -> FRST -> SETTLE -> RUN and re-runs FRST/SETTLE on overflow, skew or request.
module ad_sync_ctrl #(
   parameter int unsigned STARTUP_CYCLES  = 100_000_000,
   parameter int unsigned FIFO_RST_CYCLES = 16,
   parameter int unsigned SETTLE_CYCLES   = 64,
   parameter int unsigned SKEW_MAX        = 8,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             adc_clk100m,
   input  logic             ad_rst_n,
   input  logic             sync_req,
   input  logic             full_a,
   input  logic             full_b,
   input  logic             empty_a,
   input  logic             empty_b,
   output logic             fifo_rst,
   output logic             fifo_wr_en,
   output logic             fifo_rd_en,
   output logic             sync_locked,
   output logic [CNT_W-1:0] ovf_count,
   output logic [CNT_W-1:0] resync_count,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      StStartup = 2'd0,
      StFrst    = 2'd1,
      StSettle  = 2'd2,
      StRun     = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       phase_q, phase_d;
   logic [31:0]       skew_q, skew_d;
   logic [CNT_W-1:0]  ovf_q, ovf_d;
   logic [CNT_W-1:0]  rsy_q, rsy_d;
   logic              fifo_rst_q, run_q;
   logic              mismatch, ovf_inc, rsy_inc;

   assign mismatch = empty_a ^ empty_b;

   always_comb begin
      state_d = state_q;
      ovf_inc = 1'b0;
      rsy_inc = 1'b0;
      unique case (state_q)
         StStartup: if (phase_q == STARTUP_CYCLES - 1) state_d = StFrst;
         StFrst:    if (phase_q == FIFO_RST_CYCLES - 1) state_d = StSettle;
         StSettle: begin
            if (sync_req) begin
               state_d = StFrst;
               rsy_inc = 1'b1;
            end else if (phase_q == SETTLE_CYCLES - 1) begin
               state_d = StRun;
            end
         end
         StRun: begin
            // Exit priority: overflow, then skew, then software request.
            if (full_a || full_b) begin
               state_d = StFrst;
               ovf_inc = 1'b1;
            end else if (mismatch && (skew_q == SKEW_MAX - 1)) begin
               state_d = StFrst;
               rsy_inc = 1'b1;
            end else if (sync_req) begin
               state_d = StFrst;
               rsy_inc = 1'b1;
            end
         end
         default: state_d = StStartup;
      endcase

      phase_d = (state_d != state_q) ? 32'd0 : phase_q + 32'd1;

      skew_d = 32'd0;
      if ((state_q == StRun) && (state_d == StRun) && mismatch) begin
         skew_d = (skew_q == SKEW_MAX) ? skew_q : skew_q + 32'd1;
      end

      ovf_d = (ovf_inc && (ovf_q != {CNT_W{1'b1}})) ? ovf_q + CNT_W'(1) : ovf_q;
      rsy_d = (rsy_inc && (rsy_q != {CNT_W{1'b1}})) ? rsy_q + CNT_W'(1) : rsy_q;
   end

   // Outputs are decoded from next-state so they line up with the state they describe.
   always_ff @(posedge adc_clk100m or negedge ad_rst_n) begin
      if (!ad_rst_n) begin
         state_q    <= StStartup;
         phase_q    <= 32'd0;
         skew_q     <= 32'd0;
         ovf_q      <= '0;
         rsy_q      <= '0;
         fifo_rst_q <= 1'b0;
         run_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         skew_q     <= skew_d;
         ovf_q      <= ovf_d;
         rsy_q      <= rsy_d;
         fifo_rst_q <= (state_d == StFrst);
         run_q      <= (state_d == StRun);
      end
   end

   assign fifo_rst     = fifo_rst_q;
   assign fifo_wr_en   = run_q;
   assign sync_locked  = run_q;
   assign fifo_rd_en   = (state_q == StRun) && !empty_a && !empty_b;
   assign ovf_count    = ovf_q;
   assign resync_count = rsy_q;
   assign state_o      = state_q;

endmodule
